div_clk_monitor: RTL and testbench

Measures a divided, slow clock-like signal, such as the output of the team's clock divider, from within the fast system clock domain. It synchronises the asynchronous input and produces one-cycle rising and falling edge strobes. It measures every half-period in system cycles, checks each measurement against an expected value, and reports it through a valid/ready interface. It sits between the clock divider and any logic that must verify that divider or use it as an enable.

---
 rtl/div_clk_monitor_pkg.sv | 29 ++
 rtl/sync_edge_det.sv | 44 ++++
 rtl/div_clk_monitor.sv | 184 ++++++++++++++++++
 tb/tb_div_clk_monitor.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_clk_monitor_pkg.sv
// Shared types and defaults for the divided-clock monitor.
// The FSM state enum, default measurement constants and the tolerance check
// live here so the top and any future users agree on them.
package div_clk_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_MEASURE = 2'd2,
    ST_STUCK   = 2'd3
  } state_t;

  localparam int unsigned DEF_EXP_HALF  = 20;
  localparam int unsigned DEF_TOL       = 2;
  localparam int unsigned DEF_LOCK_CNT  = 4;
  localparam int unsigned DEF_STUCK_LIM = 80;

  // One bit wider than the widest supported counter (64 bits).
  localparam int unsigned RC_W = 65;

  // Window test written as (meas + tol >= exp) so that no subtraction exists
  // and a tolerance larger than the expected value cannot wrap the lower bound.
  function automatic logic range_ok(input logic [RC_W-1:0] meas,
                                    input logic [RC_W-1:0] exp_half,
                                    input logic [RC_W-1:0] tol);
    return ((meas + tol) >= exp_half) && (meas <= (exp_half + tol));
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-stage synchroniser with edge detection for one asynchronous input.
// Exposes both the registered one-cycle strobes and their next-cycle values,
// so a consumer can update its own registers in the same cycle as a strobe.
module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise_nxt,
  output logic o_fall_nxt,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_level;

  assign w_level    = r_sync[SYNC_STAGES-1];
  assign o_rise_nxt = w_level & ~r_prev;
  assign o_fall_nxt = ~w_level & r_prev;
  assign o_rise     = r_rise;
  assign o_fall     = r_fall;

  // Shift the input through the chain, remember the last level, register strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      // NOTE: non-blocking here so every stage samples the previous stage's old value.
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= w_level;
      r_rise <= o_rise_nxt;
      r_fall <= o_fall_nxt;
    end
  end

endmodule

// File: rtl/div_clk_monitor.sv
// Divided-clock monitor: synchronises a slow clock-like input, measures each
// half-period in clk cycles, range-checks it, tracks frequency lock and
// hands measurements out through a valid/ready interface.
// Optional feature macro: DIV_CLK_MONITOR_STUCK_EN (adds the STUCK state and
// stuck-input detection; without it err_stuck is tied low).
module div_clk_monitor
  import div_clk_monitor_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned EXP_HALF    = DEF_EXP_HALF,
  parameter int unsigned TOL         = DEF_TOL,
  parameter int unsigned LOCK_CNT    = DEF_LOCK_CNT,
  parameter int unsigned STUCK_LIM   = DEF_STUCK_LIM
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             div_clk_in,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] meas_half,
  output logic             meas_level,
  output logic             meas_ovf,
  output logic             err_range,
  output logic             err_stuck,
  output logic             locked
);

  localparam int unsigned      RUN_W   = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_meas_half;
  logic             r_meas_level;
  logic             r_meas_valid;
  logic             r_meas_ovf;
  logic             r_err_range;
  logic             r_locked;
  logic [RUN_W-1:0] r_run;

  logic             w_rise_nxt;
  logic             w_fall_nxt;
  logic             w_edge;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_in_range;
  logic [RUN_W-1:0] w_run_inc;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge_det (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_async    (div_clk_in),
    .o_rise_nxt (w_rise_nxt),
    .o_fall_nxt (w_fall_nxt),
    .o_rise     (rise_pulse),
    .o_fall     (fall_pulse)
  );

  // An edge is seen one cycle before its strobe appears, so loads below land
  // in the same cycle as the strobe and intervals equal strobe spacing.
  assign w_edge     = w_rise_nxt | w_fall_nxt;
  assign w_cnt_inc  = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + CNT_W'(1);
  assign w_in_range = range_ok(RC_W'(w_cnt_inc), RC_W'(EXP_HALF), RC_W'(TOL));
  assign w_run_inc  = (r_run == RUN_W'(LOCK_CNT)) ? r_run : r_run + RUN_W'(1);

`ifdef DIV_CLK_MONITOR_STUCK_EN
  logic r_err_stuck;
  logic w_stuck_enter;

  // Count reaching the limit without an edge, only while actively watching.
  assign w_stuck_enter = ((r_state == ST_ACQUIRE) || (r_state == ST_MEASURE)) &&
                         !w_edge && (w_cnt_inc == CNT_W'(STUCK_LIM));
  assign err_stuck     = r_err_stuck;
`else
  assign err_stuck     = 1'b0;
`endif

  assign meas_valid = r_meas_valid;
  assign meas_half  = r_meas_half;
  assign meas_level = r_meas_level;
  assign meas_ovf   = r_meas_ovf;
  assign err_range  = r_err_range;
  assign locked     = r_locked;

  // Monitor FSM with counter, handshake, range check and lock tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_meas_half  <= '0;
      r_meas_level <= 1'b0;
      r_meas_valid <= 1'b0;
      r_meas_ovf   <= 1'b0;
      r_err_range  <= 1'b0;
      r_locked     <= 1'b0;
      r_run        <= '0;
`ifdef DIV_CLK_MONITOR_STUCK_EN
      r_err_stuck  <= 1'b0;
`endif
    end else begin
      r_meas_ovf  <= 1'b0;
      r_err_range <= 1'b0;
      if (r_meas_valid && meas_ready) begin
        r_meas_valid <= 1'b0;
      end

      if (!en) begin
        r_state      <= ST_IDLE;
        r_cnt        <= '0;
        r_meas_valid <= 1'b0;
        r_run        <= '0;
        r_locked     <= 1'b0;
`ifdef DIV_CLK_MONITOR_STUCK_EN
        r_err_stuck  <= 1'b0;
      end else if (w_stuck_enter) begin
        r_state     <= ST_STUCK;
        r_cnt       <= w_cnt_inc;
        r_err_stuck <= 1'b1;
        r_run       <= '0;
        r_locked    <= 1'b0;
`endif
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_cnt    <= '0;
            r_locked <= 1'b0;
            r_state  <= ST_ACQUIRE;
          end
          // First edge only aligns the counter; the partial interval is dropped.
          ST_ACQUIRE: begin
            if (w_edge) begin
              r_cnt   <= '0;
              r_state <= ST_MEASURE;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          ST_MEASURE: begin
            if (w_edge) begin
              r_cnt        <= '0;
              r_meas_half  <= w_cnt_inc;
              r_meas_level <= w_fall_nxt;
              r_meas_valid <= 1'b1;
              r_meas_ovf   <= r_meas_valid & ~meas_ready;
              if (w_in_range) begin
                r_run    <= w_run_inc;
                r_locked <= (w_run_inc == RUN_W'(LOCK_CNT));
              end else begin
                r_err_range <= 1'b1;
                r_run       <= '0;
                r_locked    <= 1'b0;
              end
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
`ifdef DIV_CLK_MONITOR_STUCK_EN
          // Recover on the next edge without reporting the stuck interval.
          ST_STUCK: begin
            if (w_edge) begin
              r_cnt       <= '0;
              r_err_stuck <= 1'b0;
              r_state     <= ST_MEASURE;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
`endif
          // NOTE: a default arm keeps unreachable encodings recoverable.
          default: begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_clk_monitor.sv
// Self-checking bench for div_clk_monitor (default parameters).
// A timestamp-based model predicts every output each cycle from the input
// toggles the bench itself makes; directed literal checks pin the model.
// Honours DIV_CLK_MONITOR_STUCK_EN for the stuck-input expectations.
module tb_div_clk_monitor;

  localparam int S     = 2;
  localparam int EXP   = 20;
  localparam int TOL   = 2;
  localparam int LOCK  = 4;
  localparam int STUCK = 80;
`ifdef DIV_CLK_MONITOR_STUCK_EN
  localparam bit STUCK_ON = 1'b1;
`else
  localparam bit STUCK_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        div_clk_in = 1'b0;
  logic        meas_ready = 1'b0;
  logic        rise_pulse, fall_pulse, meas_valid, meas_level;
  logic        meas_ovf, err_range, err_stuck, locked;
  logic [31:0] meas_half;

  int n_chk  = 0;
  int n_fail = 0;

  div_clk_monitor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .div_clk_in (div_clk_in),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .meas_valid (meas_valid),
    .meas_ready (meas_ready),
    .meas_half  (meas_half),
    .meas_level (meas_level),
    .meas_ovf   (meas_ovf),
    .err_range  (err_range),
    .err_stuck  (err_stuck),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {int cyc; bit lvl;} ev_t;
  typedef enum {M_IDLE, M_ACQ, M_MEAS, M_STK} mmode_t;

  ev_t    sched[$];
  int     n = 0;
  mmode_t m_mode = M_IDLE;
  int     m_ref = 0, m_run = 0, m_half = 0;
  bit     m_rise, m_fall, m_valid, m_level, m_ovf, m_err, m_stuck, m_locked;

  always @(posedge clk) begin
    bit edge_now, lvl_now, v_old;
    int half;
    n++;
    edge_now = 1'b0;
    lvl_now  = 1'b0;
    if (sched.size() > 0 && sched[0].cyc == n) begin
      edge_now = 1'b1;
      lvl_now  = sched[0].lvl;
      void'(sched.pop_front());
    end
    if (!rst_n) begin
      sched.delete();
      m_mode = M_IDLE; m_ref = 0; m_run = 0; m_half = 0;
      m_rise = 0; m_fall = 0; m_valid = 0; m_level = 0;
      m_ovf = 0; m_err = 0; m_stuck = 0; m_locked = 0;
    end else begin
      m_rise = edge_now && lvl_now;
      m_fall = edge_now && !lvl_now;
      m_ovf  = 1'b0;
      m_err  = 1'b0;
      v_old  = m_valid;
      if (m_valid && meas_ready) m_valid = 1'b0;
      if (!en) begin
        m_mode = M_IDLE; m_valid = 0; m_stuck = 0; m_run = 0; m_locked = 0;
      end else if ((m_mode == M_ACQ || m_mode == M_MEAS) && !edge_now &&
                   STUCK_ON && (n - m_ref == STUCK)) begin
        m_mode = M_STK; m_stuck = 1; m_run = 0; m_locked = 0;
      end else begin
        case (m_mode)
          M_IDLE: begin m_mode = M_ACQ; m_ref = n; m_locked = 0; end
          M_ACQ:  if (edge_now) begin m_mode = M_MEAS; m_ref = n; end
          M_MEAS: if (edge_now) begin
            half    = n - m_ref;
            m_half  = half;
            m_level = !lvl_now;
            m_ovf   = v_old && !meas_ready;
            m_valid = 1'b1;
            if (half >= EXP - TOL && half <= EXP + TOL) begin
              if (m_run < LOCK) m_run++;
            end else begin
              m_err = 1'b1;
              m_run = 0;
            end
            m_locked = (m_run == LOCK);
            m_ref    = n;
          end
          M_STK:  if (edge_now) begin m_mode = M_MEAS; m_ref = n; m_stuck = 0; end
          default: m_mode = M_IDLE;
        endcase
      end
    end
  end

  // Compare process: every cycle out of reset, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("cmp_rise",   64'(rise_pulse), 64'(m_rise));
      check("cmp_fall",   64'(fall_pulse), 64'(m_fall));
      check("cmp_valid",  64'(meas_valid), 64'(m_valid));
      check("cmp_ovf",    64'(meas_ovf),   64'(m_ovf));
      check("cmp_erange", 64'(err_range),  64'(m_err));
      check("cmp_estuck", 64'(err_stuck),  64'(m_stuck));
      check("cmp_locked", 64'(locked),     64'(m_locked));
      if (m_valid) begin
        check("cmp_half",  64'(meas_half),  64'(m_half));
        check("cmp_level", 64'(meas_level), 64'(m_level));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic toggle_in();
    ev_t e;
    div_clk_in = ~div_clk_in;
    e.cyc = n + 1 + S;
    e.lvl = div_clk_in;
    sched.push_back(e);
  endtask

  // Entered at a strobe (3 cycles after the last toggle); toggles h cycles
  // after the previous toggle and returns at the new strobe.
  task automatic step(input int h);
    tick(h - 3);
    toggle_in();
    tick(3);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rise"},   64'(rise_pulse), 64'd0);
    check({tag, "_fall"},   64'(fall_pulse), 64'd0);
    check({tag, "_valid"},  64'(meas_valid), 64'd0);
    check({tag, "_half"},   64'(meas_half),  64'd0);
    check({tag, "_level"},  64'(meas_level), 64'd0);
    check({tag, "_ovf"},    64'(meas_ovf),   64'd0);
    check({tag, "_erange"}, 64'(err_range),  64'd0);
    check({tag, "_estuck"}, 64'(err_stuck),  64'd0);
    check({tag, "_locked"}, 64'(locked),     64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected completion before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bh[4];
    bit be[4];
    bh = '{22, 23, 18, 17};
    be = '{1'b0, 1'b1, 1'b0, 1'b1};

    // Reset state
    tick(2);
    check_all_zero("reset");
    rst_n = 1'b1;
    tick(1);

    // Nominal input: first interval discarded, then 20s with alternating level
    en = 1'b1;
    meas_ready = 1'b1;
    tick(2);
    toggle_in();
    tick(2);
    check("strobe_early", 64'(rise_pulse), 64'd0);
    tick(1);
    check("strobe_latency", 64'(rise_pulse), 64'd1);
    check("first_discarded", 64'(meas_valid), 64'd0);
    for (int m = 1; m <= 7; m++) begin
      step(20);
      check("nom_valid",  64'(meas_valid), 64'd1);
      check("nom_half",   64'(meas_half),  64'd20);
      check("nom_level",  64'(meas_level), 64'(m % 2));
      check("nom_erange", 64'(err_range),  64'd0);
      check("nom_locked", 64'(locked),     64'(m >= 4));
    end

    // Stuck input: held low, strobe E was the last one
    tick(79);
    check("stuck_pre",        64'(err_stuck), 64'd0);
    check("stuck_pre_locked", 64'(locked),    64'd1);
    tick(1);
    check("stuck_at_lim",     64'(err_stuck), 64'(STUCK_ON));
    check("stuck_lock_drop",  64'(locked),    64'(!STUCK_ON));
    tick(20);
    toggle_in();
    tick(3);
    check("stuck_recover", 64'(err_stuck), 64'd0);
`ifdef DIV_CLK_MONITOR_STUCK_EN
    check("stuck_no_meas", 64'(meas_valid), 64'd0);
`else
    check("long_meas_valid", 64'(meas_valid), 64'd1);
    check("long_meas_half",  64'(meas_half),  64'd103);
    check("long_erange",     64'(err_range),  64'd1);
`endif

    // Slow input
    for (int k = 0; k < 4; k++) begin
      step(25);
      check("slow_half",   64'(meas_half), 64'd25);
      check("slow_erange", 64'(err_range), 64'd1);
      check("slow_locked", 64'(locked),    64'd0);
    end

    // Tolerance boundaries
    for (int k = 0; k < 4; k++) begin
      step(bh[k]);
      check("bound_half",   64'(meas_half), 64'(bh[k]));
      check("bound_erange", 64'(err_range), 64'(be[k]));
    end

    // Back-pressure
    tick(1);
    check("bp_drained", 64'(meas_valid), 64'd0);
    meas_ready = 1'b0;
    step(19);   // entered one cycle late, so this interval is 20
    check("bp_first_half", 64'(meas_half), 64'd20);
    check("bp_first_ovf",  64'(meas_ovf),  64'd0);
    step(21);
    check("bp_ovf",        64'(meas_ovf),   64'd1);
    check("bp_latest",     64'(meas_half),  64'd21);
    tick(1);
    check("bp_ovf_once",   64'(meas_ovf),   64'd0);
    check("bp_hold_valid", 64'(meas_valid), 64'd1);
    check("bp_hold_half",  64'(meas_half),  64'd21);
    tick(16);
    toggle_in();
    tick(2);
    meas_ready = 1'b1;
    tick(1);
    check("bp_xfer_ovf",   64'(meas_ovf),   64'd0);
    check("bp_xfer_valid", 64'(meas_valid), 64'd1);
    check("bp_xfer_half",  64'(meas_half),  64'd20);

    // Disable while busy
    meas_ready = 1'b0;
    step(20);
    check("dis_busy_valid",  64'(meas_valid), 64'd1);
    check("dis_busy_locked", 64'(locked),     64'd1);
    en = 1'b0;
    tick(1);
    check("dis_valid",  64'(meas_valid), 64'd0);
    check("dis_locked", 64'(locked),     64'd0);
    toggle_in();
    tick(3);
    check("dis_strobe", 64'(div_clk_in ? rise_pulse : fall_pulse), 64'd1);
    check("dis_no_meas", 64'(meas_valid), 64'd0);

    // Reset mid-phase, with input low
    en = 1'b1;
    meas_ready = 1'b1;
    if (div_clk_in) step(20);
    tick(10);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    tick(3);
    rst_n = 1'b1;
    tick(2);
    toggle_in();
    tick(3);
    check("rst_rise",      64'(rise_pulse), 64'd1);
    check("rst_discarded", 64'(meas_valid), 64'd0);
    step(20);
    check("rst_meas_valid", 64'(meas_valid), 64'd1);
    check("rst_meas_half",  64'(meas_half),  64'd20);
    check("rst_meas_level", 64'(meas_level), 64'd1);
    tick(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
